// File: rtl/dir_controller_if.sv
// rtl/dir_controller_if.sv - request/message/ack bus between processors and the directory
//
// Purpose: groups the directory's bus-side handshakes into one bundle.
// Ports (signals):
//   req_valid/req_ready/req_op/req_src/req_tag/req_data  processor requests
//   msg_valid/msg_ready/msg_op/msg_dst/msg_tag/msg_data  directory messages
//   ack_valid/ack_src/ack_data                           owner fetch acknowledge
//   stale_wb                                             dropped-writeback pulse
// Modports: master = bus/processor side, slave = directory side.
interface dir_controller_if #(
  parameter int NUM_PROCS  = 2,
  parameter int NUM_BLOCKS = 8,
  parameter int DATA_W     = 16
);
  localparam int SRC_W = (NUM_PROCS  > 1) ? $clog2(NUM_PROCS)  : 1;
  localparam int TAG_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [SRC_W-1:0]  req_src;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] req_data;

  logic              msg_valid;
  logic              msg_ready;
  logic [1:0]        msg_op;
  logic [SRC_W-1:0]  msg_dst;
  logic [TAG_W-1:0]  msg_tag;
  logic [DATA_W-1:0] msg_data;

  logic              ack_valid;
  logic [SRC_W-1:0]  ack_src;
  logic [DATA_W-1:0] ack_data;

  logic              stale_wb;

  modport master (
    output req_valid, req_op, req_src, req_tag, req_data,
    output msg_ready, ack_valid, ack_src, ack_data,
    input  req_ready, msg_valid, msg_op, msg_dst, msg_tag, msg_data, stale_wb
  );

  modport slave (
    input  req_valid, req_op, req_src, req_tag, req_data,
    input  msg_ready, ack_valid, ack_src, ack_data,
    output req_ready, msg_valid, msg_op, msg_dst, msg_tag, msg_data, stale_wb
  );
endinterface

// File: rtl/dir_controller.sv
// rtl/dir_controller.sv - parametrised full-map directory coherence controller
//
// Purpose: one entry (DI/DS/DM state, sharer vector, data) per block; serialises
// read-miss, write-miss and writeback requests and issues invalidate, fetch and
// data-reply messages.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    dir_controller_if.slave (requests in, messages out, owner acks in,
//          stale_wb pulse out)
module dir_controller #(
  parameter int NUM_PROCS  = 2,
  parameter int NUM_BLOCKS = 8,
  parameter int DATA_W     = 16
) (
  input logic             clock,
  input logic             reset,
  dir_controller_if.slave bus
);
  localparam int SRC_W = (NUM_PROCS  > 1) ? $clog2(NUM_PROCS)  : 1;
  localparam int TAG_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  localparam logic [1:0] ST_DI = 2'd0;
  localparam logic [1:0] ST_DS = 2'd1;
  localparam logic [1:0] ST_DM = 2'd2;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_WB = 2'b10;

  localparam logic [1:0] MSG_REPLY     = 2'b00;
  localparam logic [1:0] MSG_INV       = 2'b01;
  localparam logic [1:0] MSG_FETCH     = 2'b10;
  localparam logic [1:0] MSG_FETCH_INV = 2'b11;

  typedef enum logic [2:0] {IDLE, SEND_INV, SEND_FETCH, WAIT_ACK, REPLY} state_t;

  state_t state;

  logic [1:0]           ent_state   [NUM_BLOCKS];
  logic [NUM_PROCS-1:0] ent_sharers [NUM_BLOCKS];
  logic [DATA_W-1:0]    ent_data    [NUM_BLOCKS];

  // Transaction context captured on accept.
  logic [TAG_W-1:0]     tag_q;
  logic [SRC_W-1:0]     owner_q;
  logic [NUM_PROCS-1:0] inv_left_q;
  logic [1:0]           upd_state_q;
  logic [NUM_PROCS-1:0] upd_sharers_q;
  logic                 upd_data_q;   // reply carries fetched data to store

  logic              msg_valid_q;
  logic [1:0]        msg_op_q;
  logic [SRC_W-1:0]  msg_dst_q;
  logic [TAG_W-1:0]  msg_tag_q;
  logic [DATA_W-1:0] msg_data_q;
  logic              stale_q;

  assign bus.req_ready = (state == IDLE);
  assign bus.msg_valid = msg_valid_q;
  assign bus.msg_op    = msg_op_q;
  assign bus.msg_dst   = msg_dst_q;
  assign bus.msg_tag   = msg_tag_q;
  assign bus.msg_data  = msg_data_q;
  assign bus.stale_wb  = stale_q;

  function automatic logic [NUM_PROCS-1:0] onehot(input logic [SRC_W-1:0] s);
    onehot = '0;
    for (int i = 0; i < NUM_PROCS; i++)
      if (s == SRC_W'(i)) onehot[i] = 1'b1;
  endfunction

  function automatic logic [SRC_W-1:0] lowest(input logic [NUM_PROCS-1:0] v);
    lowest = '0;
    for (int i = NUM_PROCS - 1; i >= 0; i--)
      if (v[i]) lowest = SRC_W'(i);
  endfunction

  // Decode of the entry addressed by the incoming request.
  logic                 blk_ok;
  logic [1:0]           cur_st;
  logic [NUM_PROCS-1:0] cur_sh;
  logic [DATA_W-1:0]    cur_data;
  logic [NUM_PROCS-1:0] p_bit;
  logic [NUM_PROCS-1:0] others;
  logic [SRC_W-1:0]     cur_owner;
  logic [SRC_W-1:0]     first_inv;
  logic                 is_owner;

  always_comb begin
    blk_ok   = (32'(bus.req_tag) < NUM_BLOCKS);
    cur_st   = ST_DI;
    cur_sh   = '0;
    cur_data = '0;
    if (blk_ok) begin
      cur_st   = ent_state[bus.req_tag];
      cur_sh   = ent_sharers[bus.req_tag];
      cur_data = ent_data[bus.req_tag];
    end
    p_bit     = onehot(bus.req_src);
    others    = cur_sh & ~p_bit;
    cur_owner = lowest(cur_sh);
    first_inv = lowest(others);
    is_owner  = (cur_st == ST_DM) && (cur_sh == p_bit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tag_q         <= '0;
      owner_q       <= '0;
      inv_left_q    <= '0;
      upd_state_q   <= ST_DI;
      upd_sharers_q <= '0;
      upd_data_q    <= 1'b0;
      msg_valid_q   <= 1'b0;
      msg_op_q      <= '0;
      msg_dst_q     <= '0;
      msg_tag_q     <= '0;
      msg_data_q    <= '0;
      stale_q       <= 1'b0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        ent_state[b]   <= ST_DI;
        ent_sharers[b] <= '0;
        ent_data[b]    <= '0;
      end
    end else begin
      stale_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && blk_ok) begin
            tag_q      <= bus.req_tag;
            owner_q    <= cur_owner;
            upd_data_q <= 1'b0;
            msg_tag_q  <= bus.req_tag;
            case (bus.req_op)
              OP_RD: begin
                upd_state_q   <= ST_DS;
                upd_sharers_q <= cur_sh | p_bit;  // {o,p} when fetching from owner o
                msg_valid_q   <= 1'b1;
                if (cur_st == ST_DM && !is_owner) begin
                  upd_data_q <= 1'b1;
                  msg_op_q   <= MSG_FETCH;
                  msg_dst_q  <= cur_owner;
                  msg_data_q <= '0;
                  state      <= SEND_FETCH;
                end else begin
                  if (is_owner) begin
                    upd_state_q   <= ST_DM;
                    upd_sharers_q <= cur_sh;
                  end
                  msg_op_q   <= MSG_REPLY;
                  msg_dst_q  <= bus.req_src;
                  msg_data_q <= cur_data;
                  state      <= REPLY;
                end
              end
              OP_WR: begin
                upd_state_q   <= ST_DM;
                upd_sharers_q <= p_bit;
                msg_valid_q   <= 1'b1;
                if (cur_st == ST_DM && !is_owner) begin
                  upd_data_q <= 1'b1;
                  msg_op_q   <= MSG_FETCH_INV;
                  msg_dst_q  <= cur_owner;
                  msg_data_q <= '0;
                  state      <= SEND_FETCH;
                end else if (cur_st == ST_DS && others != '0) begin
                  msg_op_q   <= MSG_INV;
                  msg_dst_q  <= first_inv;
                  msg_data_q <= '0;
                  inv_left_q <= others & ~onehot(first_inv);
                  state      <= SEND_INV;
                end else begin
                  msg_op_q   <= MSG_REPLY;
                  msg_dst_q  <= bus.req_src;
                  msg_data_q <= cur_data;
                  state      <= REPLY;
                end
              end
              OP_WB: begin
                // Only the current owner's writeback is meaningful; it
                // commits immediately and leaves the FSM in IDLE.
                if (is_owner) begin
                  ent_state[bus.req_tag]   <= ST_DI;
                  ent_sharers[bus.req_tag] <= '0;
                  ent_data[bus.req_tag]    <= bus.req_data;
                end else begin
                  stale_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        SEND_INV: begin
          if (bus.msg_ready) begin
            if (inv_left_q != '0) begin
              msg_dst_q  <= lowest(inv_left_q);
              inv_left_q <= inv_left_q & ~onehot(lowest(inv_left_q));
            end else begin
              msg_op_q   <= MSG_REPLY;
              msg_dst_q  <= lowest(upd_sharers_q);
              msg_data_q <= ent_data[tag_q];
              state      <= REPLY;
            end
          end
        end

        SEND_FETCH: begin
          if (bus.msg_ready) begin
            msg_valid_q <= 1'b0;
            msg_op_q    <= '0;
            msg_dst_q   <= '0;
            msg_tag_q   <= '0;
            state       <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (bus.ack_valid && bus.ack_src == owner_q) begin
            msg_valid_q <= 1'b1;
            msg_op_q    <= MSG_REPLY;
            // Requester is the sole new sharer on a write, and the non-owner
            // sharer on a read.
            msg_dst_q   <= lowest(upd_sharers_q & ~onehot(owner_q));
            msg_tag_q   <= tag_q;
            msg_data_q  <= bus.ack_data;
            state       <= REPLY;
          end
        end

        REPLY: begin
          if (bus.msg_ready) begin
            ent_state[tag_q]   <= upd_state_q;
            ent_sharers[tag_q] <= upd_sharers_q;
            if (upd_data_q) ent_data[tag_q] <= msg_data_q;
            msg_valid_q <= 1'b0;
            msg_op_q    <= '0;
            msg_dst_q   <= '0;
            msg_tag_q   <= '0;
            msg_data_q  <= '0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dir_controller.sv
// tb/tb_dir_controller.sv - self-checking bench for dir_controller
module tb_dir_controller;
  localparam logic [1:0] DI = 2'd0;
  localparam logic [1:0] DS = 2'd1;
  localparam logic [1:0] DM = 2'd2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dir_controller_if #(.NUM_PROCS(4), .NUM_BLOCKS(8), .DATA_W(16)) bus ();

  dir_controller #(.NUM_PROCS(4), .NUM_BLOCKS(8), .DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  src;
    logic [2:0]  tag;
    logic [15:0] wdata;
    logic        has_msg;
    logic [15:0] rdata;
    logic        stale;
    logic [1:0]  est;
    logic [3:0]  esh;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] src,
                      input logic [2:0] tag, input logic [15:0] data);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("req_ready_before_send", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src   = src;
    bus.req_tag   = tag;
    bus.req_data  = data;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
  endtask

  task automatic expect_msg(input string name, input logic [1:0] op, input logic [1:0] dst,
                            input logic [2:0] tag, input logic [15:0] data);
    @(negedge clock);
    chk({name, "_valid"}, 32'(bus.msg_valid), 32'd1);
    chk({name, "_op"},    32'(bus.msg_op),    32'(op));
    chk({name, "_dst"},   32'(bus.msg_dst),   32'(dst));
    chk({name, "_tag"},   32'(bus.msg_tag),   32'(tag));
    chk({name, "_data"},  32'(bus.msg_data),  32'(data));
  endtask

  task automatic check_entry(input string name, input int t, input logic [1:0] st,
                             input logic [3:0] sh, input logic [15:0] data);
    chk({name, "_state"},   32'(dut.ent_state[t]),   32'(st));
    chk({name, "_sharers"}, 32'(dut.ent_sharers[t]), 32'(sh));
    chk({name, "_data"},    32'(dut.ent_data[t]),    32'(data));
  endtask

  // Request that must be answered directly with a data reply.
  task automatic simple(input string name, input logic [1:0] op, input logic [1:0] src,
                        input logic [2:0] tag, input logic [15:0] rdata);
    send(op, src, tag, 16'h0);
    expect_msg(name, 2'b00, src, tag, rdata);
    @(posedge clock); #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_src   = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.msg_ready = 1'b1;
    bus.ack_valid = 1'b0;
    bus.ack_src   = '0;
    bus.ack_data  = '0;

    //        op     src tag wdata    msg   rdata    stale st  sharers  edata
    vecs[0]  = '{2'b00, 0, 3, 16'h0,    1'b1, 16'h0,    1'b0, DS, 4'b0001, 16'h0};
    vecs[1]  = '{2'b00, 2, 3, 16'h0,    1'b1, 16'h0,    1'b0, DS, 4'b0101, 16'h0};
    vecs[2]  = '{2'b01, 1, 4, 16'h0,    1'b1, 16'h0,    1'b0, DM, 4'b0010, 16'h0};
    vecs[3]  = '{2'b10, 1, 4, 16'h1234, 1'b0, 16'h0,    1'b0, DI, 4'b0000, 16'h1234};
    vecs[4]  = '{2'b00, 3, 4, 16'h0,    1'b1, 16'h1234, 1'b0, DS, 4'b1000, 16'h1234};
    vecs[5]  = '{2'b10, 0, 3, 16'h9999, 1'b0, 16'h0,    1'b1, DS, 4'b0101, 16'h0};
    vecs[6]  = '{2'b01, 3, 4, 16'h0,    1'b1, 16'h1234, 1'b0, DM, 4'b1000, 16'h1234};
    vecs[7]  = '{2'b00, 3, 4, 16'h0,    1'b1, 16'h1234, 1'b0, DM, 4'b1000, 16'h1234};
    vecs[8]  = '{2'b01, 3, 4, 16'h0,    1'b1, 16'h1234, 1'b0, DM, 4'b1000, 16'h1234};
    vecs[9]  = '{2'b11, 0, 1, 16'h5a5a, 1'b0, 16'h0,    1'b0, DI, 4'b0000, 16'h0};
    vecs[10] = '{2'b10, 2, 1, 16'haaaa, 1'b0, 16'h0,    1'b1, DI, 4'b0000, 16'h0};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_msg_valid", 32'(bus.msg_valid), 32'd0);
    chk("rst_msg_op",    32'(bus.msg_op),    32'd0);
    chk("rst_msg_dst",   32'(bus.msg_dst),   32'd0);
    chk("rst_msg_tag",   32'(bus.msg_tag),   32'd0);
    chk("rst_msg_data",  32'(bus.msg_data),  32'd0);
    chk("rst_stale_wb",  32'(bus.stale_wb),  32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_entry("rst_entry0", 0, DI, 4'b0000, 16'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Table-driven single-step transactions.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].src, vecs[i].tag, vecs[i].wdata);
      if (vecs[i].has_msg) begin
        expect_msg($sformatf("v%0d_reply", i), 2'b00, vecs[i].src, vecs[i].tag, vecs[i].rdata);
        chk($sformatf("v%0d_busy", i), 32'(bus.req_ready), 32'd0);
        @(posedge clock); #1;
      end else begin
        @(negedge clock);
        chk($sformatf("v%0d_no_msg", i), 32'(bus.msg_valid), 32'd0);
        chk($sformatf("v%0d_stale", i), 32'(bus.stale_wb), 32'(vecs[i].stale));
        chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'd1);
        @(posedge clock); #1;
        chk($sformatf("v%0d_stale_end", i), 32'(bus.stale_wb), 32'd0);
      end
      check_entry($sformatf("v%0d_entry", i), int'(vecs[i].tag), vecs[i].est, vecs[i].esh, vecs[i].edata);
    end

    // Write miss with two other sharers: invalidates on consecutive cycles.
    simple("b5_rd0", 2'b00, 2'd0, 3'd5, 16'h0);
    simple("b5_rd1", 2'b00, 2'd1, 3'd5, 16'h0);
    simple("b5_rd3", 2'b00, 2'd3, 3'd5, 16'h0);
    check_entry("b5_ds", 5, DS, 4'b1011, 16'h0);
    send(2'b01, 2'd1, 3'd5, 16'h0);
    expect_msg("inv_p0", 2'b01, 2'd0, 3'd5, 16'h0);
    expect_msg("inv_p3", 2'b01, 2'd3, 3'd5, 16'h0);
    check_entry("b5_during_inv", 5, DS, 4'b1011, 16'h0);
    expect_msg("inv_reply", 2'b00, 2'd1, 3'd5, 16'h0);
    @(posedge clock); #1;
    check_entry("b5_dm", 5, DM, 4'b0010, 16'h0);

    // Read miss on a DM block: fetch, ignore foreign ack, reply with owner data.
    simple("b2_wr1", 2'b01, 2'd1, 3'd2, 16'h0);
    send(2'b00, 2'd0, 3'd2, 16'h0);
    expect_msg("b2_fetch", 2'b10, 2'd1, 3'd2, 16'h0);
    @(posedge clock); #1;
    bus.ack_valid = 1'b1; bus.ack_src = 2'd0; bus.ack_data = 16'hdead;
    @(posedge clock); #1;
    bus.ack_valid = 1'b0;
    @(negedge clock);
    chk("wrong_ack_ignored", 32'(bus.msg_valid), 32'd0);
    chk("wait_ack_busy", 32'(bus.req_ready), 32'd0);
    bus.ack_valid = 1'b1; bus.ack_src = 2'd1; bus.ack_data = 16'hbeef;
    @(posedge clock); #1;
    bus.ack_valid = 1'b0;
    expect_msg("b2_reply", 2'b00, 2'd0, 3'd2, 16'hbeef);
    @(posedge clock); #1;
    check_entry("b2_ds", 2, DS, 4'b0011, 16'hbeef);

    // Stale and owner writebacks on a DM block.
    simple("b6_wr1", 2'b01, 2'd1, 3'd6, 16'h0);
    send(2'b10, 2'd0, 3'd6, 16'h7777);
    @(negedge clock);
    chk("wb_stale_pulse", 32'(bus.stale_wb), 32'd1);
    chk("wb_stale_no_msg", 32'(bus.msg_valid), 32'd0);
    @(posedge clock); #1;
    chk("wb_stale_one_cycle", 32'(bus.stale_wb), 32'd0);
    check_entry("b6_unchanged", 6, DM, 4'b0010, 16'h0);
    send(2'b10, 2'd1, 3'd6, 16'h1234);
    @(negedge clock);
    chk("wb_owner_no_stale", 32'(bus.stale_wb), 32'd0);
    check_entry("b6_di", 6, DI, 4'b0000, 16'h1234);

    // Back-pressure on a reply.
    bus.msg_ready = 1'b0;
    send(2'b00, 2'd2, 3'd6, 16'h0);
    for (int c = 0; c < 5; c++) begin
      expect_msg($sformatf("hold%0d", c), 2'b00, 2'd2, 3'd6, 16'h1234);
      chk($sformatf("hold%0d_busy", c), 32'(bus.req_ready), 32'd0);
      chk($sformatf("hold%0d_no_commit", c), 32'(dut.ent_state[6]), 32'(DI));
    end
    bus.msg_ready = 1'b1;
    @(posedge clock); #1;
    check_entry("b6_after_hold", 6, DS, 4'b0100, 16'h1234);
    @(negedge clock);
    chk("hold_ready_back", 32'(bus.req_ready), 32'd1);
    chk("hold_msg_gone", 32'(bus.msg_valid), 32'd0);

    // Write miss on a block owned by another processor: fetch-invalidate.
    simple("b7_wr0", 2'b01, 2'd0, 3'd7, 16'h0);
    send(2'b01, 2'd2, 3'd7, 16'h0);
    expect_msg("b7_fetchinv", 2'b11, 2'd0, 3'd7, 16'h0);
    @(posedge clock); #1;
    bus.ack_valid = 1'b1; bus.ack_src = 2'd0; bus.ack_data = 16'h5555;
    @(posedge clock); #1;
    bus.ack_valid = 1'b0;
    expect_msg("b7_reply", 2'b00, 2'd2, 3'd7, 16'h5555);
    @(posedge clock); #1;
    check_entry("b7_dm", 7, DM, 4'b0100, 16'h5555);

    // Asynchronous reset while waiting for an ack.
    send(2'b00, 2'd1, 3'd7, 16'h0);
    expect_msg("b7_fetch", 2'b10, 2'd2, 3'd7, 16'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("wait_ack_before_rst", 32'(bus.req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_msg_valid", 32'(bus.msg_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
    for (int b = 0; b < 8; b++)
      check_entry($sformatf("arst_entry%0d", b), b, DI, 4'b0000, 16'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    simple("post_rst_rd", 2'b00, 2'd0, 3'd7, 16'h0);
    check_entry("post_rst_b7", 7, DS, 4'b0001, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
